// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner: FSM states, table size and
// the golden truth table of the lab function.
package truth_table_scanner_pkg;

  // Scan sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } scan_state_e;

  // A 4-input function has 16 minterms
  localparam int NUM_MINTERMS = 16;

  // Truth table of the lab function F = AC' + B'D + A'CD + ABCD, bit i = F(i)
  localparam logic [15:0] LAB_F_MASK = 16'hBB8A;

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Loadable down-counter that times how long each minterm is held before it is
// sampled. tc is high once SETTLE cycles have elapsed since the last load.
module settle_timer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tc
);

  // The cycle in which the load lands already counts as the first settle cycle
  localparam logic [3:0] LOAD_VALUE = 4'(SETTLE - 1);

  logic [3:0] count;

  // Reload on request, otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= LOAD_VALUE;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign tc = (count == 4'd0);

endmodule

// File: rtl/truth_table_scanner.sv
// Walks a 4-input function under test through all 16 minterms in ascending
// order, captures its response into a truth table and compares it against a
// golden table latched when the scan starts.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        f_in,
  input  logic [15:0] expected,
  output logic [3:0]  abcd_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err,
  output logic        err_valid
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_MINTERMS - 1);

  scan_state_e state;
  scan_state_e state_next;

  logic [3:0]  idx;
  logic [15:0] expected_q;
  logic        timer_load;
  logic        timer_tc;
  logic        mismatch;

  // The function under test is driven straight from the minterm index register
  assign abcd_out = idx;

  // Current sample disagrees with the golden table latched at start
  assign mismatch = (f_in != expected_q[idx]);

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .tc    (timer_tc)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; the settle timer is reloaded whenever a new minterm begins
  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SETTLE;
          timer_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (timer_tc) begin
          state_next = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (idx == LAST_IDX) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_SETTLE;
          timer_load = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: clear results at start, record one minterm per SAMPLE cycle and
  // publish the verdict when the last minterm has been taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      table_out  <= 16'h0000;
      pass       <= 1'b0;
      err_count  <= 5'd0;
      first_err  <= 4'd0;
      err_valid  <= 1'b0;
      expected_q <= 16'h0000;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx        <= 4'd0;
            busy       <= 1'b1;
            table_out  <= 16'h0000;
            pass       <= 1'b0;
            err_count  <= 5'd0;
            first_err  <= 4'd0;
            err_valid  <= 1'b0;
            expected_q <= expected;
          end
        end
        ST_SAMPLE: begin
          table_out[idx] <= f_in;
          if (mismatch) begin
            err_count <= err_count + 5'd1;
            if (!err_valid) begin
              first_err <= idx;
              err_valid <= 1'b1;
            end
          end
          if (idx == LAST_IDX) begin
            // idx stays at 15 so abcd_out parks at 4'hF until the next start
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_count == 5'd0) && !mismatch;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 Parameter: SETTLE, default 2, cycles abcd_out is held before each sample; legal range 1..15.
REQ-002 Port: clk  input  1  rising-edge clock; one clock domain only.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request a full 16-minterm scan; sampled only in IDLE.
REQ-005 Port: f_in  input  1  output of the 4-input function under test.
REQ-006 Port: expected  input  16  golden truth table, bit i = F at minterm i; sampled at start acceptance.
REQ-007 Port: abcd_out  output  4  drives {a,b,c,d} of the function under test; a = bit 3 (MSB).
REQ-008 Port: busy  output  1  high from start acceptance until the last sample.
REQ-009 Port: done  output  1  one-cycle pulse when a scan completes.
REQ-010 Port: table_out  output  16  captured truth table, bit i = f_in sampled at minterm i.
REQ-011 Port: pass  output  1  table_out == expected; valid from the done pulse until the next start.
REQ-012 Port: err_count  output  5  number of mismatching minterms, 0..16.
REQ-013 Port: first_err  output  4  lowest mismatching minterm index; qualified by err_valid.
REQ-014 Port: err_valid  output  1  at least one mismatch recorded in the current or last scan.

Function
REQ-015 FSM states and transitions:
- IDLE -> SETTLE on start.
- SETTLE -> SAMPLE after SETTLE cycles.
- SAMPLE -> SETTLE when idx<15.
- SAMPLE -> DONE when idx==15.
- DONE -> IDLE unconditionally after one cycle.
REQ-016 Start acceptance (clock edge in IDLE with start=1) takes these actions:
- idx, abcd_out <= 0; busy <= 1.
- table_out, err_count, err_valid, first_err, pass <= 0.
- expected latched into an internal register.
REQ-017 abcd_out equals idx in SETTLE and SAMPLE and stays stable for all SETTLE+1 cycles of each minterm.
REQ-018 At the SAMPLE edge:
- table_out[idx] <= f_in.
- If f_in != latched expected[idx]: err_count increments; if err_valid was 0, first_err <= idx and err_valid <= 1.
REQ-019 Minterms are scanned in ascending order 0..15; idx increments only on the SAMPLE edge and never wraps mid-scan.
REQ-020 Scan latency: busy is high for exactly 16*(SETTLE+1) cycles, done is high in the following cycle, and busy=0 in DONE.
REQ-021 pass is updated on entry to DONE and equals (err_count==0 after the final sample).
REQ-022 start while busy or in DONE is ignored; a held-high start begins a new scan on the first IDLE cycle.
REQ-023 All results (table_out, pass, err_count, first_err, err_valid) hold after DONE until the next start acceptance.
REQ-024 abcd_out holds 4'hF after a scan until the next start acceptance.
REQ-025 Changes to expected after start acceptance have no effect on the current scan.
REQ-026 All outputs are registered; no combinational path from f_in or start to any output.

Reset
REQ-027 rst_n low forces state IDLE and all outputs to 0 (abcd_out 0, busy 0, done 0, table_out 0, pass 0, err_count 0, first_err 0, err_valid 0) immediately, regardless of clk.
REQ-028 Reset mid-scan aborts the scan; no done pulse is produced, and the first start after reset release starts a fresh scan at minterm 0.

Structure
REQ-029 The shared package holds:
- The state enum (IDLE, SETTLE, SAMPLE, DONE).
- NUM_MINTERMS = 16.
- LAB_F_MASK = 16'hBB8A, the truth table of the lab function F = AC' + B'D + A'CD + ABCD.
REQ-030 Exactly one sub-module, settle_timer: a loadable down-counter that signals terminal count after SETTLE cycles; everything else is inline.

Verification
REQ-031 Reset, then start with the lab function as DUT, expected=LAB_F_MASK, SETTLE=2 -> done 49 cycles after the start edge; table_out=16'hBB8A, pass=1, err_count=0, err_valid=0.
REQ-032 Same DUT, expected=16'hBB8B -> table_out=16'hBB8A, pass=0, err_count=1, first_err=0, err_valid=1.
REQ-033 f_in tied 1, expected=16'h0000 -> table_out=16'hFFFF, err_count=16, first_err=0, pass=0.
REQ-034 rst_n pulsed low while idx=7 -> all outputs read 0 before the next edge, no done pulse; then restart with expected=LAB_F_MASK -> pass=1.
REQ-035 Start pulsed at cycles 5 and 20 of a scan, and expected changed mid-scan -> single done pulse at the nominal cycle, results unaffected.
REQ-036 Check every cycle: abcd_out never changes except on a SAMPLE->SETTLE edge, and shows 0..15 in ascending order, each for SETTLE+1 cycles.
